load_store_unit: RTL and testbench

Sequential load/store unit between the ALU/core and the word-addressed data memory. Accepts one byte/halfword/word access per handshake, enforces alignment and range, sign/zero-extends load data, and performs read-modify-write for sub-word stores, since the memory only writes full 32-bit words. Memory read is combinational (`mem_rd` follows `mem_addr`) and the write is clocked on `mem_we`.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM states
// and the request legality check.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LSU_MEM_WORDS = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } lsu_state_t;

    // Width/alignment fault for a request; the range check lives in the top
    // because it depends on the memory depth parameter.
    function automatic logic req_fault(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic fault;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = addr_lo[0];
            F3_W:    fault = (addr_lo != 2'b00);
            F3_BU:   fault = we;
            F3_HU:   fault = we | addr_lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: load extraction with sign/zero
// extension and the read-modify-write merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    always_comb begin
        byte_lane = 8'h00;
        case (addr_lo)
            2'd0: byte_lane = word[7:0];
            2'd1: byte_lane = word[15:8];
            2'd2: byte_lane = word[23:16];
            2'd3: byte_lane = word[31:24];
            default: byte_lane = 8'h00;
        endcase
        half_lane = addr_lo[1] ? word[31:16] : word[15:0];

        rdata = 32'h0;
        case (funct3)
            F3_B:    rdata = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   rdata = {24'h0, byte_lane};
            F3_H:    rdata = {{16{half_lane[15]}}, half_lane};
            F3_HU:   rdata = {16'h0, half_lane};
            F3_W:    rdata = word;
            default: rdata = 32'h0;
        endcase
    end

    always_comb begin
        merged = word;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0: merged[7:0]   = wdata[7:0];
                    2'd1: merged[15:8]  = wdata[7:0];
                    2'd2: merged[23:16] = wdata[7:0];
                    2'd3: merged[31:24] = wdata[7:0];
                    default: merged = word;
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) merged[31:16] = wdata[15:0];
                else            merged[15:0]  = wdata[15:0];
            end
            F3_W:    merged = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequential load/store unit: one access per handshake, alignment and range
// checking, load extension and read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        req_bad;
    logic [31:0] align_word;
    logic [31:0] align_rdata;
    logic [31:0] align_merged;

    assign req_bad = req_fault(req_we, req_funct3, req_addr[1:0])
                   | (req_addr[31:2] >= 30'(MEM_WORDS));

    // During RD the fresh memory word is steered through; otherwise the
    // captured word keeps mem_wd stable and zero out of reset.
    assign align_word = (state == S_RD) ? mem_rd : word_q;

    lsu_align u_align (
        .word    (align_word),
        .wdata   (wdata_q),
        .addr_lo (addr_q[1:0]),
        .funct3  (funct3_q),
        .rdata   (align_rdata),
        .merged  (align_merged)
    );

    assign req_ready = (state == S_IDLE);
    assign mem_we    = (state == S_WR);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wd    = align_merged;

    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values; the async reset clears the write strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            addr_q     <= 32'h0;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            word_q     <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= S_RESP;
                        end else if (req_we && req_funct3 == F3_W) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    word_q <= mem_rd;
                    if (we_q) begin
                        state <= S_WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= align_rdata;
                        state      <= S_RESP;
                    end
                end
                S_WR: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    state      <= S_RESP;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a combinational-read word memory.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;
    int resp_cnt = 0;
    int we_cnt = 0;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
        if (mem_we) we_cnt <= we_cnt + 1;
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // One request; lat/we_at are negedge counts after the accepting edge (0 = never).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int we_at,
                         output logic [31:0] rd, output logic er);
        int budget;
        lat = 0;
        we_at = 0;
        rd = 32'hxxxxxxxx;
        er = 1'bx;
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (mem_we && we_at == 0) we_at = k;
            if (resp_valid) begin
                lat = k;
                rd = resp_rdata;
                er = resp_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mem_we_held: got %b expected 0", mem_we);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: got valid=%b err=%b expected 0 0", resp_valid, resp_err);
        end
        checks++;
        if (resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 00000000", resp_rdata);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_port: got we=%b addr=%h wd=%h expected 0 0 0",
                     mem_we, mem_addr, mem_wd);
        end
    endtask

    task automatic test_word_round_trip();
        int lat, wat;
        logic [31:0] rd;
        logic er;
        issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, lat, wat, rd, er);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL sw_latency: got %0d expected 2", lat);
        end
        checks++;
        if (wat !== 1) begin
            errors++;
            $display("FAIL sw_we_cycle: got %0d expected 1", wat);
        end
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_resp: got err=%b rdata=%h expected 0 00000000", er, rd);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL sw_mem: got %h expected deadbeef", mem[4]);
        end
        issue(1'b0, F3_W, 32'h10, 32'h0, lat, wat, rd, er);
        checks++;
        if (lat !== 2 || wat !== 0) begin
            errors++;
            $display("FAIL lw_timing: got lat=%0d we_at=%0d expected 2 0", lat, wat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL lw_data: got %h err=%b expected deadbeef 0", rd, er);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_hold: got valid=%b rdata=%h expected 0 deadbeef",
                     resp_valid, resp_rdata);
        end
    endtask

    task automatic test_byte();
        int lat, wat;
        logic [31:0] rd;
        logic er;
        issue(1'b1, F3_W, 32'h20, 32'h11223344, lat, wat, rd, er);
        issue(1'b1, F3_B, 32'h22, 32'hFFFFFFA5, lat, wat, rd, er);
        checks++;
        if (lat !== 3 || wat !== 2) begin
            errors++;
            $display("FAIL sb_timing: got lat=%0d we_at=%0d expected 3 2", lat, wat);
        end
        checks++;
        if (mem[8] !== 32'h11A53344) begin
            errors++;
            $display("FAIL sb_merge: got %h expected 11a53344", mem[8]);
        end
        issue(1'b0, F3_B, 32'h22, 32'h0, lat, wat, rd, er);
        checks++;
        if (rd !== 32'hFFFFFFA5 || lat !== 2) begin
            errors++;
            $display("FAIL lb_sext: got %h lat=%0d expected ffffffa5 2", rd, lat);
        end
        issue(1'b0, F3_BU, 32'h22, 32'h0, lat, wat, rd, er);
        checks++;
        if (rd !== 32'h000000A5) begin
            errors++;
            $display("FAIL lbu_zext: got %h expected 000000a5", rd);
        end
        issue(1'b0, F3_BU, 32'h23, 32'h0, lat, wat, rd, er);
        checks++;
        if (rd !== 32'h00000011) begin
            errors++;
            $display("FAIL lbu_lane3: got %h expected 00000011", rd);
        end
    endtask

    task automatic test_half();
        int lat, wat;
        logic [31:0] rd;
        logic er;
        issue(1'b1, F3_W, 32'h24, 32'h0, lat, wat, rd, er);
        issue(1'b1, F3_H, 32'h26, 32'h12348001, lat, wat, rd, er);
        checks++;
        if (lat !== 3 || mem[9] !== 32'h80010000) begin
            errors++;
            $display("FAIL sh_merge: got %h lat=%0d expected 80010000 3", mem[9], lat);
        end
        issue(1'b0, F3_H, 32'h26, 32'h0, lat, wat, rd, er);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_sext: got %h expected ffff8001", rd);
        end
        issue(1'b0, F3_HU, 32'h26, 32'h0, lat, wat, rd, er);
        checks++;
        if (rd !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu_zext: got %h expected 00008001", rd);
        end
        issue(1'b0, F3_B, 32'h27, 32'h0, lat, wat, rd, er);
        checks++;
        if (rd !== 32'hFFFFFF80) begin
            errors++;
            $display("FAIL lb_lane3: got %h expected ffffff80", rd);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
    } err_vec_t;

    task automatic test_errors();
        int lat, wat, we0;
        logic [31:0] rd;
        logic er;
        err_vec_t vecs [5];
        vecs = '{'{1'b0, 3'b010, 32'h13}, '{1'b1, 3'b001, 32'h21},
                 '{1'b0, 3'b011, 32'h10}, '{1'b0, 3'b010, 32'h100},
                 '{1'b1, 3'b100, 32'h10}};
        we0 = we_cnt;
        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].we, vecs[i].f3, vecs[i].a, 32'hFFFFFFFF, lat, wat, rd, er);
            checks++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wat !== 0) begin
                errors++;
                $display("FAIL err_path%0d: got lat=%0d err=%b rdata=%h we_at=%0d expected 1 1 00000000 0",
                         i, lat, er, rd, wat);
            end
        end
        @(negedge clk);
        checks++;
        if (we_cnt !== we0) begin
            errors++;
            $display("FAIL err_no_write: got %0d writes expected 0", we_cnt - we0);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF || mem[8] !== 32'h11A53344) begin
            errors++;
            $display("FAIL err_mem_intact: got %h %h expected deadbeef 11a53344", mem[4], mem[8]);
        end
        mem[63] = 32'hCAFEF00D;
        issue(1'b0, F3_W, 32'hFC, 32'h0, lat, wat, rd, er);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lw_last_word: got lat=%0d err=%b rdata=%h expected 2 0 cafef00d", lat, er, rd);
        end
    endtask

    task automatic test_back_to_back();
        int a0, r0, budget;
        logic [5:0] ready_tr, resp_tr;
        logic [31:0] rd2;
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        a0 = acc_cnt;
        r0 = resp_cnt;
        rd2 = 32'h0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = F3_W;
        req_addr = 32'h10;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            ready_tr[k] = req_ready;
            resp_tr[k] = resp_valid;
            if (k == 4) begin
                rd2 = resp_rdata;
                req_valid = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (ready_tr !== 6'b100100) begin
            errors++;
            $display("FAIL b2b_ready: got %b expected 100100", ready_tr);
        end
        checks++;
        if (resp_tr !== 6'b010010) begin
            errors++;
            $display("FAIL b2b_resp: got %b expected 010010", resp_tr);
        end
        checks++;
        if (acc_cnt - a0 !== 2 || resp_cnt - r0 !== 2) begin
            errors++;
            $display("FAIL b2b_counts: got acc=%0d resp=%0d expected 2 2", acc_cnt - a0, resp_cnt - r0);
        end
        checks++;
        if (rd2 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL b2b_data: got %h expected deadbeef", rd2);
        end
    endtask

    task automatic test_reset_mid_store();
        int r0, budget, lat, wat;
        logic [31:0] rd;
        logic er;
        mem[12] = 32'h55667788;
        budget = 0;
        @(negedge clk);
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = F3_B;
        req_addr = 32'h31;
        req_wdata = 32'h000000AA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        r0 = resp_cnt;
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_wr: got mem_we=%b expected 1", mem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_we_drop: got %b expected 0", mem_we);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem[12] !== 32'h55667788) begin
            errors++;
            $display("FAIL rst_mid_mem: got %h expected 55667788", mem[12]);
        end
        checks++;
        if (resp_cnt !== r0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_resp: got resps=%0d ready=%b expected 0 1", resp_cnt - r0, req_ready);
        end
        issue(1'b0, F3_W, 32'h30, 32'h0, lat, wat, rd, er);
        checks++;
        if (lat !== 2 || rd !== 32'h55667788) begin
            errors++;
            $display("FAIL rst_mid_reload: got lat=%0d rdata=%h expected 2 55667788", lat, rd);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_word_round_trip();
        test_byte();
        test_half();
        test_errors();
        test_back_to_back();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
